// File: rtl/fusion_blend.sv
// fusion_blend: three-stage per-pixel blend out = round((w*new + (max-w)*old)/max) with frame markers.
// Optional `FUSE_STATS_EN adds sel_count/stats_valid: per-frame count of pixels with weight >= half scale.
module fusion_blend #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512
) (
    input  logic                                   clk,
    input  logic                                   aresetn,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [INPUT_WIDTH*PIXELS_PER_BEAT-1:0] w_map,
    input  logic [INPUT_WIDTH*PIXELS_PER_BEAT-1:0] old_img,
    input  logic [INPUT_WIDTH*PIXELS_PER_BEAT-1:0] new_img,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [INPUT_WIDTH*PIXELS_PER_BEAT-1:0] m_data,
    output logic                                   m_sof,
    output logic                                   m_eol,
    output logic                                   m_eof
`ifdef FUSE_STATS_EN
    ,
    output logic [$clog2(IMAGE_DIM*IMAGE_DIM):0]   sel_count,
    output logic                                   stats_valid
`endif
);
    localparam int W     = INPUT_WIDTH;
    localparam int P     = PIXELS_PER_BEAT;
    localparam int PW    = 2 * W;
    localparam int SW    = 2 * W + 1;
    localparam int BEATS = IMAGE_DIM / P;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = IMAGE_DIM > 1 ? $clog2(IMAGE_DIM) : 1;
    localparam logic [W-1:0]  WMAX = {W{1'b1}};
    localparam logic [SW-1:0] HALF = SW'(1) << (W - 1);

    logic                 en, xfer, beat_last, line_last;
    logic                 v1_q, v1_d, v2_q, v2_d, m_valid_q, m_valid_d;
    logic [P-1:0][PW-1:0] a_q, a_d, b_q, b_d;
    logic [P-1:0][SW-1:0] s_q, s_d;
    logic [P-1:0][W-1:0]  data_q, data_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [LW-1:0]        line_cnt_q, line_cnt_d;

    assign en        = ~m_valid_q | m_ready;
    assign s_ready   = en;
    assign xfer      = m_valid_q & m_ready;
    assign beat_last = beat_cnt_q == BW'(BEATS - 1);
    assign line_last = line_cnt_q == LW'(IMAGE_DIM - 1);
    assign m_valid   = m_valid_q;
    assign m_data    = data_q;
    assign m_sof     = m_valid_q & (beat_cnt_q == '0) & (line_cnt_q == '0);
    assign m_eol     = m_valid_q & beat_last;
    assign m_eof     = m_eol & line_last;

    always_comb begin
        v1_d      = en ? s_valid : v1_q;
        v2_d      = en ? v1_q : v2_q;
        m_valid_d = en ? v2_q : m_valid_q;
        for (int j = 0; j < P; j++) begin
            a_d[j]    = en ? PW'(w_map[j*W +: W]) * PW'(new_img[j*W +: W]) : a_q[j];
            b_d[j]    = en ? PW'(WMAX - w_map[j*W +: W]) * PW'(old_img[j*W +: W]) : b_q[j];
            s_d[j]    = en ? SW'(a_q[j]) + SW'(b_q[j]) + HALF : s_q[j];
            // (s + s>>W) >> W is an exact divide-by-max with rounding over the product range
            data_d[j] = en ? W'((s_q[j] + (s_q[j] >> W)) >> W) : data_q[j];
        end
        beat_cnt_d = xfer ? (beat_last ? '0 : beat_cnt_q + BW'(1)) : beat_cnt_q;
        line_cnt_d = (xfer & beat_last) ? (line_last ? '0 : line_cnt_q + LW'(1)) : line_cnt_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            data_q     <= '0;
            beat_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            m_valid_q  <= m_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            data_q     <= data_d;
            beat_cnt_q <= beat_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

`ifdef FUSE_STATS_EN
    localparam int CW = $clog2(IMAGE_DIM * IMAGE_DIM) + 1;

    logic [P-1:0]  sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d;
    logic [CW-1:0] acc_q, acc_d, sel_count_q, sel_count_d, beat_sel;
    logic          stats_valid_q, stats_valid_d;

    // Weight MSB travels with the beat so the count matches the transferred data
    always_comb begin
        beat_sel = '0;
        for (int j = 0; j < P; j++) begin
            sel1_d[j] = en ? w_map[j*W + W - 1] : sel1_q[j];
            beat_sel  = beat_sel + CW'(sel3_q[j]);
        end
        sel2_d        = en ? sel1_q : sel2_q;
        sel3_d        = en ? sel2_q : sel3_q;
        acc_d         = xfer ? (m_eof ? '0 : acc_q + beat_sel) : acc_q;
        sel_count_d   = (xfer & m_eof) ? acc_q + beat_sel : sel_count_q;
        stats_valid_d = xfer & m_eof;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sel1_q        <= '0;
            sel2_q        <= '0;
            sel3_q        <= '0;
            acc_q         <= '0;
            sel_count_q   <= '0;
            stats_valid_q <= 1'b0;
        end else begin
            sel1_q        <= sel1_d;
            sel2_q        <= sel2_d;
            sel3_q        <= sel3_d;
            acc_q         <= acc_d;
            sel_count_q   <= sel_count_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    assign sel_count   = sel_count_q;
    assign stats_valid = stats_valid_q;
`endif
endmodule

// File: tb/tb_fusion_blend.sv
// tb_fusion_blend: directed self-checking bench for fusion_blend (default build, stats feature off).
module tb_fusion_blend;
    localparam int PPB = 16;
    localparam int IW  = 8;
    localparam int DIM = 512;
    localparam int BPL = DIM / PPB;
    localparam int BPF = BPL * DIM;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              s_valid, s_ready, m_valid, m_ready, m_sof, m_eol, m_eof;
    logic [PPB*IW-1:0] w_map, old_img, new_img, m_data;
    int                checks = 0;
    int                failures = 0;

    fusion_blend #(.PIXELS_PER_BEAT(PPB), .INPUT_WIDTH(IW), .IMAGE_DIM(DIM)) dut (
        .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
        .w_map(w_map), .old_img(old_img), .new_img(new_img),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gw(int i, int j);
        return 8'((i * 16 + j) & 255);
    endfunction
    function automatic logic [7:0] gn(int i, int j);
        return 8'((i * 7 + j * 31 + 3) & 255);
    endfunction
    function automatic logic [7:0] go(int i, int j);
        return 8'((i * 13 + j * 5 + 77) & 255);
    endfunction
    function automatic logic [7:0] ref_pix(logic [7:0] w, logic [7:0] n, logic [7:0] o);
        int x = int'(w) * int'(n) + (255 - int'(w)) * int'(o);
        return 8'((2 * x + 255) / 510);
    endfunction
    function automatic logic [PPB*IW-1:0] exp_beat(int i);
        logic [PPB*IW-1:0] r;
        for (int j = 0; j < PPB; j++) r[j*IW +: IW] = ref_pix(gw(i, j), gn(i, j), go(i, j));
        return r;
    endfunction

    task automatic drive_beat(int i);
        for (int j = 0; j < PPB; j++) begin
            w_map[j*IW +: IW]   = gw(i, j);
            new_img[j*IW +: IW] = gn(i, j);
            old_img[j*IW +: IW] = go(i, j);
        end
    endtask
    task automatic set_const(logic [7:0] w, logic [7:0] n, logic [7:0] o);
        w_map   = {PPB{w}};
        new_img = {PPB{n}};
        old_img = {PPB{o}};
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic apply_reset();
        aresetn = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        set_const(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h want=0", m_data); end
        checks++; if ({m_sof, m_eol, m_eof} !== 3'b000) begin failures++; $display("FAIL reset_markers got=%b want=000", {m_sof, m_eol, m_eof}); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_latency();
        m_ready = 1'b1;
        set_const(8'hFF, 8'hAB, 8'h12);
        s_valid = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL lat_s_ready got=%b want=1", s_ready); end
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL lat_cycle1 got=%b want=0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL lat_cycle2 got=%b want=0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL lat_cycle3 got=%b want=1", m_valid); end
        checks++; if (m_data !== {PPB{8'hAB}}) begin failures++; $display("FAIL lat_data got=%h want=%h", m_data, {PPB{8'hAB}}); end
        checks++; if ({m_sof, m_eol, m_eof} !== 3'b100) begin failures++; $display("FAIL lat_markers got=%b want=100", {m_sof, m_eol, m_eof}); end
        tick();
    endtask

    task automatic test_values();
        logic [7:0] wv[3] = '{8'd0, 8'd128, 8'd64};
        logic [7:0] ev[3] = '{8'd100, 8'd150, 8'd125};
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            m_ready = 1'b1;
            set_const(wv[k], 8'd200, 8'd100);
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            while (!m_valid && n < 10) begin tick(); n++; end
            checks++;
            if (m_data !== {PPB{ev[k]}}) begin
                failures++; $display("FAIL value_w%0d got=%h want=%h", wv[k], m_data, {PPB{ev[k]}});
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        int in_i = 0, out_i = 0, cyc = 0;
        m_ready = 1'b1;
        while (out_i < 256 && cyc < 400) begin
            s_valid = in_i < 256;
            drive_beat(in_i);
            #1;
            if (m_valid && m_ready) begin
                for (int j = 0; j < PPB; j++) begin
                    logic [7:0] e = ref_pix(gw(out_i, j), gn(out_i, j), go(out_i, j));
                    checks++;
                    if (m_data[j*IW +: IW] !== e) begin
                        failures++; $display("FAIL sweep beat=%0d pix=%0d w=%0d got=%0d want=%0d", out_i, j, gw(out_i, j), m_data[j*IW +: IW], e);
                    end
                end
                out_i++;
            end
            if (s_valid && s_ready) in_i++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (cyc !== 259) begin failures++; $display("FAIL sweep_throughput cycles=%0d want=259", cyc); end
    endtask

    task automatic test_stall();
        int acc = 0, got = 0;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_valid = 1'b1;
            set_const(8'hFF, 8'(acc + 1), 8'h00);
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== {PPB{8'd1}}) begin failures++; $display("FAIL stall_hold cycle=%0d got=%h want=%h", c, m_data, {PPB{8'd1}}); end
            end
            if (s_valid && s_ready) acc++;
            tick();
        end
        #1;
        checks++; if (acc !== 3) begin failures++; $display("FAIL stall_accepted got=%0d want=3", acc); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL stall_s_ready got=%b want=0", s_ready); end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 10 && got < 3; c++) begin
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== {PPB{8'(got + 1)}}) begin failures++; $display("FAIL stall_order idx=%0d got=%h want=%h", got, m_data, {PPB{8'(got + 1)}}); end
                got++;
            end
            tick();
        end
        checks++; if (got !== 3) begin failures++; $display("FAIL stall_drain got=%0d want=3", got); end
    endtask

    task automatic test_frame_stream();
        int in_i = 0, out_i = 0, cyc = 0, eol_n = 0, eof_n = 0;
        apply_reset();
        while (out_i < BPF + 1 && cyc < 60000) begin
            s_valid = in_i < BPF + 1;
            drive_beat(in_i);
            m_ready = $urandom_range(0, 3) != 0;
            #1;
            if (m_valid && m_ready) begin
                logic [2:0] em = {out_i % BPF == 0, out_i % BPL == BPL - 1, out_i % BPF == BPF - 1};
                checks++;
                if (m_data !== exp_beat(out_i)) begin failures++; $display("FAIL stream_data beat=%0d got=%h want=%h", out_i, m_data, exp_beat(out_i)); end
                checks++;
                if ({m_sof, m_eol, m_eof} !== em) begin failures++; $display("FAIL stream_markers beat=%0d got=%b want=%b", out_i, {m_sof, m_eol, m_eof}, em); end
                if (out_i < BPF) begin eol_n += int'(m_eol); eof_n += int'(m_eof); end
                out_i++;
            end
            if (s_valid && s_ready) in_i++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (out_i !== BPF + 1) begin failures++; $display("FAIL stream_timeout beats=%0d want=%0d", out_i, BPF + 1); end
        checks++; if (eol_n !== DIM) begin failures++; $display("FAIL stream_eol_count got=%0d want=%0d", eol_n, DIM); end
        checks++; if (eof_n !== 1) begin failures++; $display("FAIL stream_eof_count got=%0d want=1", eof_n); end
    endtask

    task automatic test_reset_mid_frame();
        int in_i = 0, cyc = 0, n = 0;
        apply_reset();
        m_ready = 1'b1;
        while (in_i < 5000 && cyc < 6000) begin
            s_valid = 1'b1;
            drive_beat(in_i);
            #1;
            if (s_valid && s_ready) in_i++;
            tick();
            cyc++;
        end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL mid_pipe_full got=%b want=1", m_valid); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({m_valid, m_sof, m_eol, m_eof} !== 4'b0000) begin failures++; $display("FAIL mid_reset_ctrl got=%b want=0000", {m_valid, m_sof, m_eol, m_eof}); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL mid_reset_data got=%h want=0", m_data); end
        s_valid = 1'b0;
        tick();
        aresetn = 1'b1;
        set_const(8'hFF, 8'h5A, 8'h00);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        while (!m_valid && n < 10) begin tick(); n++; end
        checks++; if (m_sof !== 1'b1) begin failures++; $display("FAIL mid_next_sof got=%b want=1", m_sof); end
        checks++; if (m_data !== {PPB{8'h5A}}) begin failures++; $display("FAIL mid_next_data got=%h want=%h", m_data, {PPB{8'h5A}}); end
        tick();
    endtask

    initial begin
        aresetn = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        set_const(0, 0, 0);
        test_reset();
        test_latency();
        test_values();
        test_sweep();
        test_stall();
        test_frame_stream();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
